regfile_2w2r_sb: RTL
====================

Name: regfile_2w2r_sb

Overview:
Parametrised general-purpose register file for the pipelined CPU core. It provides two combinational read ports and two write ports: port 0 carries the ALU writeback and port 1 carries the load/memory writeback. It supports optional write-to-read bypass and an optional hardwired zero register. A per-register pending scoreboard marks registers with an outstanding load, so the decode stage can detect load-use hazards.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; the file holds 2**ADDR_W registers
BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads show array contents only
ZERO_REG, 1, 1 = register 0 reads as 0, is never written and is never pending

Ports:
CLK  in  1  clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high reset
ra0  in  ADDR_W  read address, port A
ra1  in  ADDR_W  read address, port B
rd0  out  DATA_W  read data, port A
rd1  out  DATA_W  read data, port B
busy0  out  1  register at ra0 is pending
busy1  out  1  register at ra1 is pending
we0  in  1  write enable, port 0 (ALU)
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (load); also clears the pending bit
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
iss_en  in  1  a load is issued to register iss_addr; set its pending bit
iss_addr  in  ADDR_W  destination register of the issued load
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset: when Reset=1 at a rising edge:
  - all registers are cleared to 0;
  - all pending bits are cleared;
  - pend_cnt becomes 0.
  Reset has priority over every write, issue and clear in that cycle. While Reset=1, bypass is suppressed, so rd0/rd1 reflect array contents.
- After reset, all outputs are 0 (rd*, busy*, pend_cnt) until the first write or issue.
- Writes: at the rising edge, Reg[wa0]<=wd0 if we0=1, and Reg[wa1]<=wd1 if we1=1. There is one cycle of latency into the array.
- Write conflict: if we0=we1=1 and wa0==wa1, port 1 wins; port 0's data is discarded.
- Zero register (ZERO_REG=1):
  - writes to address 0 are ignored;
  - rd* returns 0 for address 0;
  - iss_en with iss_addr=0 is ignored;
  - busy* for address 0 is 0.
- Reads: combinational.
  - BYPASS=1: rdN equals wd1 if we1 && wa1==raN; else wd0 if we0 && wa0==raN; else Reg[raN]. The zero-register rule overrides bypass.
  - BYPASS=0: rdN = Reg[raN].
- Scoreboard, one bit per register, updated at the rising edge:
  - set when iss_en=1 for iss_addr;
  - cleared when we1=1 for wa1;
  - set and clear on the same address in the same cycle: set wins (a new load is issued behind the completing one);
  - we0 never affects pending bits;
  - issuing to a register that is already pending leaves it pending, and pend_cnt does not change.
- busyN is combinational from the pending bit of raN. It is not bypassed: a clear at this edge is visible the next cycle.
- pend_cnt: registered.
  - It equals the population count of the pending bits after every edge.
  - It increments by 1 on a 0->1 transition, decrements by 1 on a 1->0 transition, and is unchanged when both happen on different addresses in the same cycle.
  - Range 0..2**ADDR_W (0..2**ADDR_W-1 when ZERO_REG=1). It cannot overflow or wrap.
- Reset mid-operation (pending loads outstanding):
  - all pending state is discarded;
  - a we1 arriving after reset writes data normally;
  - that write's clear of an already-clear bit has no effect and does not decrement pend_cnt below 0.
- X-safety: with we0=we1=iss_en=0, no state changes regardless of address or data values.

Test Plan:
1. Reset, then we0=1, wa0=3, wd0=0x12345678. The next cycle ra0=3 gives rd0=0x12345678. Same cycle with BYPASS=1, ra1=3 gives rd1=0x12345678 before the edge.
2. Same-address conflict: we0=we1=1, wa0=wa1=7, wd0=0xAAAA0000, wd1=0x5555FFFF. The bypass read and the next-cycle array read of reg 7 both give 0x5555FFFF.
3. Zero register: we0=1, wa0=0, wd0=0xFFFFFFFF, and iss_en=1, iss_addr=0. Result: rd0 with ra0=0 is 0, busy0=0, pend_cnt=0.
4. Scoreboard sequence:
   - issue to 5, then to 9: pend_cnt=2, busy for 5 and 9 is 1;
   - we1 to 5 in the same cycle as an issue to 12: pend_cnt=2, busy5=0, busy12=1;
   - iss_en to 9 and we1 to 9 in the same cycle: busy9 stays 1.
5. Reset mid-operation: issue to 4 and 6, write reg 4=0x77, then Reset=1 for one cycle. Result: pend_cnt=0, rd of reg 4 is 0. A subsequent we1 to 6 writes the value and pend_cnt stays 0.
6. BYPASS=0 build: we0 to 2 with 0xDEAD and ra0=2 in the same cycle gives the old value 0. The next cycle gives 0xDEAD.

Source files
------------

// File: rtl/regfile_2w2r_sb.sv
// Two-write/two-read register file with a load-pending scoreboard for load-use hazard detection.
// Latency: reads and busy flags are combinational; writes, issues and pend_cnt update one edge later.
// Backpressure: none; every write, issue and clear is accepted in the cycle it is presented.
module regfile_2w2r_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              busy0,
    output logic              busy1,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [N];
    logic [N-1:0]      pend;

    // Register 0 is hardwired when ZERO_REG is set: writes and issues to it are dropped.
    logic wr0_ok, wr1_ok, iss_ok;
    assign wr0_ok = we0 && !(ZERO_REG != 0 && wa0 == '0);
    assign wr1_ok = we1 && !(ZERO_REG != 0 && wa1 == '0);
    assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);

    // A new issue only counts if the bit was clear; a clear only counts if the bit was set
    // and is not being re-armed by an issue to the same register this cycle.
    logic set_new, clr_hit;
    assign set_new = iss_ok && !pend[iss_addr];
    assign clr_hit = we1 && pend[wa1] && !(iss_ok && iss_addr == wa1);

    // Array update; port 1 is assigned last so it wins a same-address conflict.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else begin
            if (wr0_ok) regs[wa0] <= wd0;
            if (wr1_ok) regs[wa1] <= wd1;
        end
    end

    // Scoreboard and pending count; the issue is applied after the clear so set wins.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (we1)    pend[wa1]      <= 1'b0;
            if (iss_ok) pend[iss_addr] <= 1'b1;
            pend_cnt <= pend_cnt + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_hit);
        end
    end

    // Read port A: load writeback bypass has priority over ALU bypass, zero register overrides all.
    always_comb begin
        rd0 = regs[ra0];
        if (BYPASS != 0 && !Reset) begin
            if (we1 && wa1 == ra0)      rd0 = wd1;
            else if (we0 && wa0 == ra0) rd0 = wd0;
        end
        if (ZERO_REG != 0 && ra0 == '0) rd0 = '0;
    end

    // Read port B: same selection as port A.
    always_comb begin
        rd1 = regs[ra1];
        if (BYPASS != 0 && !Reset) begin
            if (we1 && wa1 == ra1)      rd1 = wd1;
            else if (we0 && wa0 == ra1) rd1 = wd0;
        end
        if (ZERO_REG != 0 && ra1 == '0) rd1 = '0;
    end

    // Busy flags come straight from the registered scoreboard (no bypass of a same-edge clear).
    assign busy0 = pend[ra0];
    assign busy1 = pend[ra1];

endmodule
